// File: rtl/and_vector_sequencer.sv
// and_vector_sequencer: drives an 11-entry operand table into a two-lane AND
// system, waits SETTLE cycles, then compares y_0/y_1 against a&b.
// It counts mismatches, records the first failing index and reports pass/fail.
// Optional feature macro: AND_SEQ_STOP_ON_ERR_EN (end the run at the first mismatch).
module and_vector_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_0,
  input  logic [2:0] y_1,
  output logic       a_0,
  output logic       b_0,
  output logic [2:0] a_1,
  output logic [2:0] b_1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [3:0] err_idx
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] LAST_IDX  = 4'd10;
  localparam logic [3:0] NO_ERR    = 4'hF;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic [7:0] vec;        // {a_0, b_0, a_1, b_1}
  logic       mismatch;
  logic       stop_now;

  // Operand table lookup for the current vector index
  always_comb begin
    vec = '0;
    unique case (idx)
      4'd0:    vec = {1'b0, 1'b0, 3'd0, 3'd0};
      4'd1:    vec = {1'b1, 1'b0, 3'd0, 3'd0};
      4'd2:    vec = {1'b1, 1'b1, 3'd0, 3'd0};
      4'd3:    vec = {1'b1, 1'b1, 3'd3, 3'd0};
      4'd4:    vec = {1'b1, 1'b1, 3'd3, 3'd1};
      4'd5:    vec = {1'b0, 1'b1, 3'd3, 3'd1};
      4'd6:    vec = {1'b0, 1'b1, 3'd1, 3'd3};
      4'd7:    vec = {1'b1, 1'b0, 3'd1, 3'd3};
      4'd8:    vec = {1'b1, 1'b0, 3'd0, 3'd3};
      4'd9:    vec = {1'b1, 1'b1, 3'd0, 3'd3};
      4'd10:   vec = {1'b1, 1'b0, 3'd0, 3'd3};
      default: vec = '0;
    endcase
  end

  // Compare sampled results against the operands still held in the registers
  always_comb begin
    mismatch = (y_0 != (a_0 & b_0)) || (y_1 != (a_1 & b_1));
`ifdef AND_SEQ_STOP_ON_ERR_EN
    stop_now = mismatch || (idx == LAST_IDX);
`else
    stop_now = (idx == LAST_IDX);
`endif
  end

  // Sequencer FSM with registered operands, status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      a_0       <= 1'b0;
      b_0       <= 1'b0;
      a_1       <= '0;
      b_1       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_idx   <= NO_ERR;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx       <= '0;
            err_count <= '0;
            err_idx   <= NO_ERR;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          {a_0, b_0, a_1, b_1} <= vec;
          cnt   <= SETTLE_LD;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != 4'hF) err_count <= err_count + 4'd1;
            if (err_idx == NO_ERR) err_idx <= idx;
          end
          if (stop_now) begin
            // pass is resolved here so it is valid alongside the done pulse
            pass  <= (err_count == 4'd0) && !mismatch;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 4'd1;
            state <= DRIVE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          a_0   <= 1'b0;
          b_0   <= 1'b0;
          a_1   <= '0;
          b_1   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_vector_sequencer.sv
// Self-checking bench for and_vector_sequencer: an AND-system stand-in with
// injectable stuck-at faults feeds y_0/y_1, and a cycle-count model derived
// from the vector table predicts every output on every cycle.
module tb_and_vector_sequencer;
  localparam int S  = 2;
  localparam int VL = S + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       y_0;
  logic [2:0] y_1;
  logic       a_0, b_0;
  logic [2:0] a_1, b_1;
  logic       busy, done, pass;
  logic [3:0] err_count, err_idx;

  // fault injection on the AND-system stand-in
  logic       f0_s0 = 1'b0, f0_s1 = 1'b0;
  logic [2:0] f1_s0 = '0, f1_s1 = '0;

  int checks = 0;
  int failures = 0;

  int ta0 [11] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
  int tb0 [11] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 0};
  int ta1 [11] = '{0, 0, 0, 3, 3, 3, 1, 1, 0, 0, 0};
  int tb1 [11] = '{0, 0, 0, 0, 1, 1, 3, 3, 3, 3, 3};

  and_vector_sequencer #(.SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_0(y_0), .y_1(y_1),
    .a_0(a_0), .b_0(b_0), .a_1(a_1), .b_1(b_1),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  assign y_0 = f0_s0 ? 1'b0 : (f0_s1 ? 1'b1 : (a_0 & b_0));
  assign y_1 = ((a_1 & b_1) & ~f1_s0) | f1_s1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // would vector v be reported as a mismatch under the current faults
  function automatic bit vfail(input int v);
    int e0, e1, g0, g1;
    e0 = ta0[v] & tb0[v];
    e1 = ta1[v] & tb1[v];
    g0 = f0_s0 ? 0 : (f0_s1 ? 1 : e0);
    g1 = (e1 & ~int'(f1_s0) & 7) | int'(f1_s1);
    return (g0 != e0) || (g1 != e1);
  endfunction

  // number of vectors a run executes
  function automatic int nvec();
`ifdef AND_SEQ_STOP_ON_ERR_EN
    for (int v = 0; v < 11; v++) if (vfail(v)) return v + 1;
`endif
    return 11;
  endfunction

  function automatic void tally(input int n, output int c, output int f);
    c = 0;
    f = 15;
    for (int v = 0; v < n; v++) begin
      if (vfail(v)) begin
        if (c < 15) c++;
        if (f == 15) f = v;
      end
    end
  endfunction

  // model: run position in cycles since the accepted start edge
  bit m_run = 1'b0;
  int m_t = 0;
  int m_cnt = 0, m_idx = 15, m_pass = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_t = 0; m_cnt = 0; m_idx = 15; m_pass = 0;
    end else if (!m_run) begin
      if (start) begin m_run = 1'b1; m_t = 0; end
    end else if (m_t == nvec() * VL) begin
      m_run = 1'b0;
      tally(nvec(), m_cnt, m_idx);
      m_pass = (m_cnt == 0) ? 1 : 0;
    end else begin
      m_t++;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    int v, p, n, c, f, ea0, eb0, ea1, eb1, eb, ed, ep;
    if (rst_n) begin
      if (m_run) begin
        v = m_t / VL;
        p = m_t % VL;
        if (p == 0) begin
          if (v == 0) begin ea0 = 0; eb0 = 0; ea1 = 0; eb1 = 0; end
          else begin ea0 = ta0[v-1]; eb0 = tb0[v-1]; ea1 = ta1[v-1]; eb1 = tb1[v-1]; end
        end else begin
          ea0 = ta0[v]; eb0 = tb0[v]; ea1 = ta1[v]; eb1 = tb1[v];
        end
        n = (v < nvec()) ? v : nvec();
        tally(n, c, f);
        eb = 1;
        ed = (m_t == nvec() * VL) ? 1 : 0;
        ep = ed ? ((c == 0) ? 1 : 0) : 0;
      end else begin
        ea0 = 0; eb0 = 0; ea1 = 0; eb1 = 0;
        eb = 0; ed = 0; c = m_cnt; f = m_idx; ep = m_pass;
      end
      chk("operands", {a_0, b_0, a_1, b_1}, (ea0 << 7) | (eb0 << 6) | (ea1 << 3) | eb1);
      chk("busy", busy, eb);
      chk("done", done, ed);
      chk("pass", pass, ep);
      chk("err_count", err_count, c);
      chk("err_idx", err_idx, f);
    end
  end

  task automatic set_faults(input bit s0, input bit s1, input logic [2:0] m0, input logic [2:0] m1);
    f0_s0 = s0; f0_s1 = s1; f1_s0 = m0; f1_s1 = m1;
  endtask

  // one run from the current negedge; returns edges from start edge to done
  task automatic do_run(input bit noise, output int lat);
    lat = -1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (done) begin lat = n; break; end
      @(negedge clk);
      if (noise) start = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ops"}, {a_0, b_0, a_1, b_1}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_errcnt"}, err_count, 0);
    chk({tag, "_erridx"}, err_idx, 15);
  endtask

  initial begin
    int lat;
    int bound;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // golden model
    set_faults(0, 0, 3'd0, 3'd0);
    do_run(0, lat);
    chk("golden_latency", lat, 44);
    chk("golden_pass", pass, 1);
    chk("golden_errcnt", err_count, 0);
    chk("golden_erridx", err_idx, 15);

    // y_0 stuck at 0
    set_faults(1, 0, 3'd0, 3'd0);
    do_run(0, lat);
`ifdef AND_SEQ_STOP_ON_ERR_EN
    chk("y0s0_latency", lat, 12);
    chk("y0s0_errcnt", err_count, 1);
`else
    chk("y0s0_latency", lat, 44);
    chk("y0s0_errcnt", err_count, 4);
`endif
    chk("y0s0_erridx", err_idx, 2);
    chk("y0s0_pass", pass, 0);

    // y_1[1] stuck at 1
    set_faults(0, 0, 3'd0, 3'b010);
    do_run(0, lat);
`ifndef AND_SEQ_STOP_ON_ERR_EN
    chk("y1b1_errcnt", err_count, 11);
`endif
    chk("y1b1_erridx", err_idx, 0);
    chk("y1b1_pass", pass, 0);

    // reset during idx 5, then a clean golden run
    set_faults(0, 0, 3'd0, 3'd0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5 * VL + 1) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_run(0, lat);
    chk("after_reset_latency", lat, 44);
    chk("after_reset_pass", pass, 1);

    // start noise while busy must not disturb timing or results
    set_faults(1, 0, 3'd0, 3'd0);
    do_run(1, lat);
`ifndef AND_SEQ_STOP_ON_ERR_EN
    chk("noise_latency", lat, 44);
    chk("noise_errcnt", err_count, 4);
`endif
    set_faults(0, 0, 3'd0, 3'd0);
    do_run(1, lat);
    chk("noise_golden_latency", lat, 44);
    chk("noise_golden_pass", pass, 1);

    // start held across DONE re-arms immediately; model follows every cycle
    start = 1'b1;
    bound = 0;
    while (!done && bound < 200) begin @(negedge clk); bound++; end
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    bound = 0;
    while (!done && bound < 200) begin @(negedge clk); bound++; end
    if (bound >= 200) chk("rearm_timeout", 0, 1);
    repeat (3) @(negedge clk);

    // randomized fault patterns and start noise
    for (int r = 0; r < 8; r++) begin
      set_faults($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0,
                 ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run($urandom_range(0, 1) == 1, lat);
      chk("rand_latency", lat, nvec() * VL);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
